// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed hex-digit scan controller.
// Each digit gets a slot of SLOT_CYCLES clocks: BLANK_CYCLES dark cycles
// (anti-ghosting) followed by the SHOW phase driving that digit's anode.
// New values are captured into a shadow register on load and only promoted
// to the displayed register at the frame boundary, so a frame never tears.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_mask,
   output logic [3:0]              nibble_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int CW = $clog2(SLOT_CYCLES);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int VW = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {BLANK, SHOW} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic                    show_en, show_en_nxt;
   logic [VW-1:0]           shadow_reg, disp_reg, disp_nxt;
   logic [NUM_DIGITS-1:0]   digit_sel_nxt;
   logic [3:0]              nibble_nxt;
   logic                    frame_done_nxt;

   // Select one bit of the mask by a run-time digit index.
   function automatic logic pick_bit(input logic [NUM_DIGITS-1:0] m,
                                     input logic [IW-1:0] i);
      logic b;
      b = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++)
         if (IW'(j) == i) b = m[j];
      return b;
   endfunction

   // Select one nibble of a packed digit vector by a run-time digit index.
   function automatic logic [3:0] pick_nib(input logic [VW-1:0] v,
                                           input logic [IW-1:0] i);
      logic [3:0] n;
      n = 4'h0;
      for (int j = 0; j < NUM_DIGITS; j++)
         if (IW'(j) == i) n = v[4*j +: 4];
      return n;
   endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // A digit is eligible if it is digit 0 or it or any more significant
   // nibble is non-zero.
   function automatic logic lead_ok(input logic [VW-1:0] v,
                                    input logic [IW-1:0] i);
      logic ok;
      ok = (i == '0);
      for (int j = 0; j < NUM_DIGITS; j++)
         if ((IW'(j) >= i) && (v[4*j +: 4] != 4'h0)) ok = 1'b1;
      return ok;
   endfunction
`endif

   // Next-state logic: slot counter, digit index, phase and registered outputs.
   // Outputs are computed from next-cycle values so they line up with the
   // counter they describe.
   always_comb begin
      cnt_nxt        = cnt + CW'(1);
      idx_nxt        = idx;
      state_nxt      = state;
      show_en_nxt    = show_en;
      disp_nxt       = disp_reg;
      digit_sel_nxt  = '1;
      nibble_nxt     = 4'h0;
      frame_done_nxt = 1'b0;

      if (cnt == LAST_CNT) begin
         cnt_nxt = '0;
         idx_nxt = (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end

      if (cnt_nxt < BLANK_CNT) state_nxt = BLANK;
      else                     state_nxt = SHOW;

      // The frame_done cycle is the last of the frame; promote on its edge.
      if (frame_done) disp_nxt = shadow_reg;

      // Enable is decided once per slot, on entry to SHOW.
      if ((state == BLANK) && (state_nxt == SHOW)) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
         show_en_nxt = pick_bit(digit_mask, idx_nxt) & lead_ok(disp_nxt, idx_nxt);
`else
         show_en_nxt = pick_bit(digit_mask, idx_nxt);
`endif
      end

      if ((state_nxt == SHOW) && show_en_nxt) begin
         for (int j = 0; j < NUM_DIGITS; j++)
            digit_sel_nxt[j] = (IW'(j) != idx_nxt);
      end

      nibble_nxt     = pick_nib(disp_nxt, idx_nxt);
      frame_done_nxt = (cnt_nxt == LAST_CNT) && (idx_nxt == LAST_IDX);
   end

   // Scan state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= BLANK;
         cnt        <= '0;
         idx        <= '0;
         show_en    <= 1'b0;
         digit_sel  <= '1;
         nibble_out <= 4'h0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         show_en    <= show_en_nxt;
         digit_sel  <= digit_sel_nxt;
         nibble_out <= nibble_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Capture/display double buffer; a load on the boundary cycle stays pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_reg <= '0;
         disp_reg   <= '0;
         pending    <= 1'b0;
      end else begin
         if (load) shadow_reg <= value_in;
         disp_reg <= disp_nxt;
         if (frame_done)  pending <= load;
         else if (load)   pending <= 1'b1;
      end
   end

endmodule
